// File: rtl/coin_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : coin_io_ctrl
//  Purpose  : Memory-mapped coin peripheral sitting on the processor dmem port.
//             Word addresses MMIO_BASE..MMIO_BASE+3 hit the peripheral
//             registers (STATUS, COIN, DISPENSE, BALANCE). Every other address
//             passes through to the data RAM. Coin-acceptor events are queued
//             in a FIFO. A pulse-timed FSM drives the coin dispenser solenoid.
//  Ports    : clock, reset             - clock, synchronous active-high reset
//             address_dmem, data, wren - processor memory-stage access
//             q_dmem                   - load data returned to the processor
//             ram_wren, q_ram          - data RAM write enable / load data
//             coin_valid, coin_type    - coin-inserted strobe and denomination
//             dispense_pulse           - registered solenoid drive
//             dispense_busy            - dispenser FSM not idle
//  Config   : define COIN_IO_BALANCE_EN to build the 32-bit BALANCE register.
//             When it is undefined, BALANCE reads 0 and ignores writes.
//  Revision : 1.0 - initial release
// ============================================================================
module coin_io_ctrl #(
  parameter logic [31:0] MMIO_BASE    = 32'h0000_F000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          PULSE_CYCLES = 4,
  parameter int          GAP_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        ram_wren,
  input  logic [31:0] q_ram,
  input  logic        coin_valid,
  input  logic [1:0]  coin_type,
  output logic        dispense_pulse,
  output logic        dispense_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  // The timer only ever holds 0..TMAX-1.
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  logic       w_hit;
  logic [1:0] w_off;
  logic       w_reg_wr;
  logic       w_wr_status;
  logic       w_wr_coin;
  logic       w_wr_disp;

  assign w_hit       = (address_dmem[31:2] == MMIO_BASE[31:2]);
  assign w_off       = address_dmem[1:0];
  assign w_reg_wr    = wren & w_hit;
  assign w_wr_status = w_reg_wr && (w_off == 2'd0);
  assign w_wr_coin   = w_reg_wr && (w_off == 2'd1);
  assign w_wr_disp   = w_reg_wr && (w_off == 2'd2);

  // ---------------------------------------------------------------- FIFO
  logic [1:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf_set;

  assign w_empty   = (r_occ == '0);
  assign w_full    = (r_occ == OCC_FULL);
  assign w_pop     = w_wr_coin & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = coin_valid & (~w_full | w_pop);
  assign w_ovf_set = coin_valid & w_full & ~w_pop;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wptr] <= coin_type;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      // Setting the sticky flag takes priority over a software clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && data[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- dispenser
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } disp_state_t;

  disp_state_t      r_state;
  disp_state_t      w_state_nxt;
  logic [7:0]       r_count;
  logic [7:0]       w_count_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             r_pulse;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_disp && (data[7:0] != 8'd0)) begin
          w_state_nxt = ST_PULSE;
          w_count_nxt = data[7:0];
          w_timer_nxt = '0;
        end
      end
      ST_PULSE: begin
        if (r_timer == PULSE_LAST) begin
          w_state_nxt = ST_GAP;
          w_count_nxt = r_count - 8'd1;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_GAP: begin
        // The gap always runs to completion, including after the last coin.
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = (r_count != 8'd0) ? ST_PULSE : ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 8'd0;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= 8'd0;
      r_timer <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
      // Dedicated flop so the solenoid drive is glitch-free.
      r_pulse <= (w_state_nxt == ST_PULSE);
    end
  end

  assign dispense_pulse = r_pulse;
  assign dispense_busy  = (r_state != ST_IDLE);

  // ---------------------------------------------------------------- balance
  logic [31:0] w_balance_rd;

`ifdef COIN_IO_BALANCE_EN
  logic        w_wr_bal;
  logic [31:0] w_coin_cents;
  logic [31:0] r_balance;

  assign w_wr_bal = w_reg_wr && (w_off == 2'd3);

  always_comb begin
    case (coin_type)
      2'd0:    w_coin_cents = 32'd1;
      2'd1:    w_coin_cents = 32'd5;
      2'd2:    w_coin_cents = 32'd10;
      default: w_coin_cents = 32'd25;
    endcase
  end

  // Only accepted pushes are credited; a same-cycle write takes the new base.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_balance <= 32'd0;
    end else if (w_wr_bal) begin
      r_balance <= data + (w_push ? w_coin_cents : 32'd0);
    end else if (w_push) begin
      r_balance <= r_balance + w_coin_cents;
    end
  end

  assign w_balance_rd = r_balance;
`else
  logic [23:0] w_unused_data;
  assign w_unused_data = data[31:8];
  assign w_balance_rd  = 32'd0;
`endif

  // ---------------------------------------------------------------- read mux
  logic [31:0] w_reg_rdata;

  always_comb begin
    w_reg_rdata = 32'd0;
    case (w_off)
      2'd0:    w_reg_rdata = {28'd0, r_ovf, dispense_busy, w_full, ~w_empty};
      2'd1:    w_reg_rdata = w_empty ? 32'd0 : {30'd0, r_fifo[r_rptr]};
      2'd2:    w_reg_rdata = {24'd0, r_count};
      default: w_reg_rdata = w_balance_rd;
    endcase
  end

  assign q_dmem   = w_hit ? w_reg_rdata : q_ram;
  assign ram_wren = wren & ~w_hit;

endmodule
`default_nettype wire
